// File: rtl/block_transfer_sequencer_if.sv
// block_transfer_sequencer_if: pipeline/regfile/memory signals of the LDM/STM sequencer
interface block_transfer_sequencer_if #(parameter int ADDRESS_LEN = 32, parameter int REG_COUNT = 16);
  logic                   start;
  logic                   is_load;
  logic                   inc;
  logic                   pre;
  logic [ADDRESS_LEN-1:0] base;
  logic [REG_COUNT-1:0]   reg_list;
  logic [3:0]             rf_src;
  logic [ADDRESS_LEN-1:0] rf_data;
  logic [3:0]             rf_dest;
  logic [ADDRESS_LEN-1:0] rf_wb_value;
  logic                   rf_wb_en;
  logic [ADDRESS_LEN-1:0] mem_addr;
  logic                   mem_rd;
  logic                   mem_wr;
  logic [ADDRESS_LEN-1:0] mem_wdata;
  logic [ADDRESS_LEN-1:0] mem_rdata;
  logic                   mem_ready;
  logic                   busy;
  logic                   done;
  logic [ADDRESS_LEN-1:0] final_addr;
  modport master (
    output start, is_load, inc, pre, base, reg_list, rf_data, mem_rdata, mem_ready,
    input  rf_src, rf_dest, rf_wb_value, rf_wb_en, mem_addr, mem_rd, mem_wr, mem_wdata,
           busy, done, final_addr
  );
  modport slave (
    input  start, is_load, inc, pre, base, reg_list, rf_data, mem_rdata, mem_ready,
    output rf_src, rf_dest, rf_wb_value, rf_wb_en, mem_addr, mem_rd, mem_wr, mem_wdata,
           busy, done, final_addr
  );
endinterface

// File: rtl/block_transfer_sequencer.sv
// block_transfer_sequencer: walks an LDM/STM register list one memory beat per register
module block_transfer_sequencer #(
  parameter int ADDRESS_LEN = 32,
  parameter int REG_COUNT   = 16
) (
  input logic clk,
  input logic rst,
  block_transfer_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam int CW = $clog2(REG_COUNT + 1);
  state_t                 r_state, w_next;
  logic [REG_COUNT-1:0]   r_list;
  logic                   r_is_load;
  logic [ADDRESS_LEN-1:0] r_addr, r_final, w_scaled;
  logic [CW-1:0]          w_count;
  logic [3:0]             w_idx;
  logic                   w_last, w_st, w_ld;
  always_comb begin
    w_count = '0;
    for (int i = 0; i < REG_COUNT; i++) w_count = w_count + CW'(bus.reg_list[i]);
    w_idx = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--) if (r_list[i]) w_idx = 4'(i);
  end
  assign w_scaled = ADDRESS_LEN'(w_count) << 2;
  // Only one bit left means this beat finishes the list
  assign w_last = (r_list & (r_list - 1'b1)) == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE ? (bus.start ? (w_count == '0 ? DONE : XFER) : IDLE) :
             r_state == XFER ? (bus.mem_ready && w_last ? DONE : XFER) : IDLE;
    w_st = r_state == XFER && !r_is_load;
    w_ld = r_state == XFER && r_is_load;
    bus.busy = r_state != IDLE;
    bus.done = r_state == DONE;
    bus.mem_addr = r_state == XFER ? r_addr : '0;
    bus.mem_wr = w_st;
    bus.mem_rd = w_ld;
    bus.rf_src = w_st ? w_idx : '0;
    bus.mem_wdata = w_st ? bus.rf_data : '0;
    bus.rf_dest = w_ld ? w_idx : '0;
    bus.rf_wb_en = w_ld && bus.mem_ready;
    bus.rf_wb_value = w_ld && bus.mem_ready ? bus.mem_rdata : '0;
  end
  assign bus.final_addr = r_final;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_list <= '0;
      r_is_load <= 1'b0;
      r_addr <= '0;
      r_final <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_list <= bus.reg_list;
      r_is_load <= bus.is_load;
      // Lowest address first: decrementing blocks start below the base
      r_addr <= bus.inc ? bus.base + ADDRESS_LEN'(bus.pre ? 4 : 0)
                        : bus.base - w_scaled + ADDRESS_LEN'(bus.pre ? 0 : 4);
      r_final <= bus.inc ? bus.base + w_scaled : bus.base - w_scaled;
    end else if (r_state == XFER && bus.mem_ready) begin
      r_list <= r_list & (r_list - 1'b1);
      r_addr <= r_addr + ADDRESS_LEN'(4);
    end
endmodule

// File: tb/tb_block_transfer_sequencer.sv
// tb_block_transfer_sequencer: directed LDM/STM scenarios with hand-computed expectations
module tb_block_transfer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  block_transfer_sequencer_if #(.ADDRESS_LEN(32), .REG_COUNT(16)) bif ();
  block_transfer_sequencer #(.ADDRESS_LEN(32), .REG_COUNT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.slave)
  );
  always #5 clk = ~clk;
  assign bif.rf_data = 32'hD000_0000 | 32'(bif.rf_src);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_o(input string t, input logic b, input logic d, input logic rd,
                       input logic wr, input logic [31:0] a);
    chk({t, "/busy"}, 32'(bif.busy), 32'(b));
    chk({t, "/done"}, 32'(bif.done), 32'(d));
    chk({t, "/rd"}, 32'(bif.mem_rd), 32'(rd));
    chk({t, "/wr"}, 32'(bif.mem_wr), 32'(wr));
    chk({t, "/addr"}, bif.mem_addr, a);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic l, input logic i, input logic p, input logic [31:0] b,
                     input logic [15:0] lst);
    bif.is_load = l;
    bif.inc = i;
    bif.pre = p;
    bif.base = b;
    bif.reg_list = lst;
    bif.start = 1'b1;
  endtask
  initial begin
    bif.start = 0; bif.is_load = 0; bif.inc = 0; bif.pre = 0;
    bif.base = 0; bif.reg_list = 0; bif.mem_rdata = 0; bif.mem_ready = 1;
    tick();
    chk_o("rst", 0, 0, 0, 0, 0);
    chk("rst/final", bif.final_addr, 0);
    chk("rst/wb_en", 32'(bif.rf_wb_en), 0);
    rst = 1'b0;
    tick();
    // STM 0x0013 incrementing, post-index from 0x100
    cmd(0, 1, 0, 32'h100, 16'h0013);
    #1 chk_o("s1c0", 0, 0, 0, 0, 0);
    tick(); bif.start = 0;
    #1 chk_o("s1c1", 1, 0, 0, 1, 32'h100);
    chk("s1c1/src", 32'(bif.rf_src), 0);
    chk("s1c1/wdata", bif.mem_wdata, 32'hD000_0000);
    tick();
    #1 chk_o("s1c2", 1, 0, 0, 1, 32'h104);
    chk("s1c2/wdata", bif.mem_wdata, 32'hD000_0001);
    tick();
    #1 chk_o("s1c3", 1, 0, 0, 1, 32'h108);
    chk("s1c3/src", 32'(bif.rf_src), 4);
    chk("s1c3/wdata", bif.mem_wdata, 32'hD000_0004);
    tick();
    #1 chk_o("s1c4", 1, 1, 0, 0, 0);
    chk("s1c4/final", bif.final_addr, 32'h10C);
    tick();
    #1 chk_o("s1c5", 0, 0, 0, 0, 0);
    // LDM 0x8001 decrementing, pre-index from 0x200
    cmd(1, 0, 1, 32'h200, 16'h8001);
    tick(); bif.start = 0; bif.mem_rdata = 32'hAA;
    #1 chk_o("l1c1", 1, 0, 1, 0, 32'h1F8);
    chk("l1c1/dest", 32'(bif.rf_dest), 0);
    chk("l1c1/wb_en", 32'(bif.rf_wb_en), 1);
    chk("l1c1/wb_val", bif.rf_wb_value, 32'hAA);
    tick(); bif.mem_rdata = 32'hBB;
    #1 chk_o("l1c2", 1, 0, 1, 0, 32'h1FC);
    chk("l1c2/dest", 32'(bif.rf_dest), 15);
    chk("l1c2/wb_en", 32'(bif.rf_wb_en), 1);
    chk("l1c2/wb_val", bif.rf_wb_value, 32'hBB);
    tick();
    #1 chk_o("l1c3", 1, 1, 0, 0, 0);
    chk("l1c3/wb_en", 32'(bif.rf_wb_en), 0);
    chk("l1c3/final", bif.final_addr, 32'h1F8);
    tick();
    // LDM 0x0006 from 0x300 with three wait cycles on the second beat
    cmd(1, 1, 0, 32'h300, 16'h0006);
    tick(); bif.start = 0; bif.mem_rdata = 32'h11;
    #1 chk_o("l2c1", 1, 0, 1, 0, 32'h300);
    chk("l2c1/dest", 32'(bif.rf_dest), 1);
    chk("l2c1/wb_en", 32'(bif.rf_wb_en), 1);
    for (int c = 2; c <= 4; c++) begin
      tick(); bif.mem_ready = 0;
      #1 chk_o($sformatf("l2c%0d", c), 1, 0, 1, 0, 32'h304);
      chk($sformatf("l2c%0d/dest", c), 32'(bif.rf_dest), 2);
      chk($sformatf("l2c%0d/wb_en", c), 32'(bif.rf_wb_en), 0);
    end
    tick(); bif.mem_ready = 1; bif.mem_rdata = 32'h22;
    #1 chk_o("l2c5", 1, 0, 1, 0, 32'h304);
    chk("l2c5/wb_en", 32'(bif.rf_wb_en), 1);
    chk("l2c5/wb_val", bif.rf_wb_value, 32'h22);
    tick();
    #1 chk_o("l2c6", 1, 1, 0, 0, 0);
    chk("l2c6/final", bif.final_addr, 32'h308);
    tick();
    // Empty list
    cmd(0, 1, 0, 32'h400, 16'h0000);
    tick(); bif.start = 0;
    #1 chk_o("e0c1", 1, 1, 0, 0, 0);
    chk("e0c1/final", bif.final_addr, 32'h400);
    tick();
    #1 chk_o("e0c2", 0, 0, 0, 0, 0);
    // Reset during the second beat of a 4-register STM
    cmd(0, 1, 0, 32'h500, 16'h000F);
    tick(); bif.start = 0;
    #1 chk_o("r0c1", 1, 0, 0, 1, 32'h500);
    tick();
    #1 chk_o("r0c2", 1, 0, 0, 1, 32'h504);
    rst = 1'b1;
    #1 chk_o("r0rst", 0, 0, 0, 0, 0);
    chk("r0rst/src", 32'(bif.rf_src), 0);
    chk("r0rst/wdata", bif.mem_wdata, 0);
    chk("r0rst/final", bif.final_addr, 0);
    tick(); rst = 1'b0;
    tick();
    cmd(0, 1, 0, 32'h600, 16'h0001);
    tick(); bif.start = 0;
    #1 chk_o("r1c1", 1, 0, 0, 1, 32'h600);
    chk("r1c1/wdata", bif.mem_wdata, 32'hD000_0000);
    tick();
    #1 chk_o("r1c2", 1, 1, 0, 0, 0);
    chk("r1c2/final", bif.final_addr, 32'h604);
    tick();
    // Wrap-around with start re-pulsed while busy
    cmd(0, 1, 0, 32'hFFFF_FFFC, 16'h0003);
    tick(); cmd(1, 0, 1, 32'h0, 16'h00FF);
    #1 chk_o("w0c1", 1, 0, 0, 1, 32'hFFFF_FFFC);
    tick(); bif.start = 0;
    #1 chk_o("w0c2", 1, 0, 0, 1, 32'h0);
    chk("w0c2/src", 32'(bif.rf_src), 1);
    tick(); bif.start = 1;
    #1 chk_o("w0c3", 1, 1, 0, 0, 0);
    chk("w0c3/final", bif.final_addr, 32'h4);
    tick(); bif.start = 0;
    #1 chk_o("w0c4", 0, 0, 0, 0, 0);
    tick();
    #1 chk_o("w0c5", 0, 0, 0, 0, 0);
    chk("w0c5/final", bif.final_addr, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
